// File: rtl/rr_mux_bus_pkg.sv
// Shared definitions for the mux_bus family: arbitration mode encodings and
// the index-width helper used to size port-select fields.
package rr_mux_bus_pkg;

    // Arbitration mode encodings
    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

    // Width of a port index; never narrower than one bit so a single-port
    // instance still has a legal select field.
    function automatic int unsigned port_bits(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin / fixed-priority arbiter with burst lock. Owns the priority
// pointer and the lock registers; grant is combinational from the requests.
module rr_arbiter
    import rr_mux_bus_pkg::*;
#(
    parameter  int unsigned NUM_PORTS = 4,
    parameter  int unsigned ARB_MODE  = ARB_RR,
    localparam int unsigned PORT_BITS = port_bits(NUM_PORTS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic                 i_advance,
    input  logic [NUM_PORTS-1:0] i_lock,
    output logic [NUM_PORTS-1:0] o_grant,
    output logic [PORT_BITS-1:0] o_grant_idx
);

    logic [PORT_BITS-1:0] r_ptr;
    logic [PORT_BITS-1:0] r_lock_port;
    logic                 r_locked;

    logic                 w_found;
    logic [PORT_BITS-1:0] w_cand;
    logic [PORT_BITS-1:0] w_ptr_next;
    int unsigned          w_base;
    int unsigned          w_sum;

    // Pick the granted port: the locked owner only, else the first requester
    // found searching upward from the base (pointer in RR mode, 0 in fixed).
    always_comb begin
        w_found     = 1'b0;
        o_grant_idx = '0;
        w_cand      = '0;
        w_sum       = 0;
        w_base      = (ARB_MODE == ARB_FIXED) ? 0 : 32'(r_ptr);
        if (r_locked) begin
            // A locked owner that is not requesting yields a bubble.
            w_found     = i_req[r_lock_port];
            o_grant_idx = r_lock_port;
        end else begin
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                w_sum = w_base + k;
                if (w_sum >= NUM_PORTS) begin
                    w_sum = w_sum - NUM_PORTS;
                end
                w_cand = w_sum[PORT_BITS-1:0];
                if (!w_found && i_req[w_cand]) begin
                    w_found     = 1'b1;
                    o_grant_idx = w_cand;
                end
            end
        end
    end

    // Expand the chosen index into a one-hot grant (all zero when nothing wins).
    always_comb begin
        o_grant = '0;
        if (w_found) begin
            o_grant[o_grant_idx] = 1'b1;
        end
    end

    // Pointer successor of the granted port, wrapping at NUM_PORTS.
    always_comb begin
        if (32'(o_grant_idx) + 32'd1 >= NUM_PORTS) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = o_grant_idx + 1'b1;
        end
    end

    // Update pointer and lock on every accepted transfer.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr       <= '0;
            r_locked    <= 1'b0;
            r_lock_port <= '0;
        end else if (i_advance) begin
            // The lock request of the winning port decides whether the bus
            // stays with it; a transfer without lock releases it.
            r_locked    <= i_lock[o_grant_idx];
            r_lock_port <= o_grant_idx;
            if (ARB_MODE == ARB_RR) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

endmodule

// File: rtl/rr_mux_bus.sv
// Registered, arbitrated N:1 bus mux. One arbiter picks a requester, its word
// is captured in a single output register with valid/ready backpressure.
module rr_mux_bus
    import rr_mux_bus_pkg::*;
#(
    parameter  int unsigned WIDTH     = 8,
    parameter  int unsigned NUM_PORTS = 4,
    parameter  int unsigned ARB_MODE  = ARB_RR,
    localparam int unsigned PORT_BITS = port_bits(NUM_PORTS)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_PORTS-1:0]       in_valid,
    input  logic [NUM_PORTS-1:0]       in_lock,
    input  logic [WIDTH*NUM_PORTS-1:0] data_in,
    output logic [NUM_PORTS-1:0]       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [PORT_BITS-1:0]       out_port,
    input  logic                       out_ready
);

    logic [NUM_PORTS-1:0] w_grant;
    logic [PORT_BITS-1:0] w_grant_idx;
    logic                 w_space;
    logic                 w_xfer;
    logic [WIDTH-1:0]     w_words [NUM_PORTS];
    logic [WIDTH-1:0]     w_sel_data;

    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_out_data;
    logic [PORT_BITS-1:0] r_out_port;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .ARB_MODE  (ARB_MODE)
    ) u_arbiter (
        .clock       (clock),
        .reset       (reset),
        .i_req       (in_valid),
        .i_advance   (w_xfer),
        .i_lock      (in_lock),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    // Slice the packed input bus into per-port words.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_words
        assign w_words[i] = data_in[WIDTH*i +: WIDTH];
    end

    // Data select, space and handshake logic.
    always_comb begin
        w_sel_data = w_words[w_grant_idx];
        // Register is empty or being drained, so it can take a new word.
        w_space    = !r_out_valid || out_ready;
        in_ready   = reset ? '0 : (w_grant & {NUM_PORTS{w_space}});
        w_xfer     = |(in_valid & in_ready);
    end

    // Output control state: fill on transfer, empty on drain without refill.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_port  <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_port  <= w_grant_idx;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Data register is not reset; its contents are masked while invalid.
    always_ff @(posedge clock) begin
        if (w_xfer) begin
            r_out_data <= w_sel_data;
        end
    end

    // Drive outputs; data reads as zero whenever the register is empty.
    always_comb begin
        out_valid = r_out_valid;
        out_port  = r_out_port;
        out_data  = r_out_valid ? r_out_data : '0;
    end

endmodule

// File: tb/tb_rr_mux_bus.sv
// Directed bench for rr_mux_bus: one round-robin and one fixed-priority
// instance share the same stimulus; expected values are hand-computed.
module tb_rr_mux_bus;
    import rr_mux_bus_pkg::*;

    localparam int unsigned W = 8;
    localparam int unsigned N = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_lock;
    logic [W*N-1:0]   data_in;
    logic             out_ready;

    logic [N-1:0]     rr_in_ready;
    logic             rr_out_valid;
    logic [W-1:0]     rr_out_data;
    logic [1:0]       rr_out_port;

    logic [N-1:0]     fx_in_ready;
    logic             fx_out_valid;
    logic [W-1:0]     fx_out_data;
    logic [1:0]       fx_out_port;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    rr_mux_bus #(
        .WIDTH     (W),
        .NUM_PORTS (N),
        .ARB_MODE  (ARB_RR)
    ) u_dut_rr (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_lock   (in_lock),
        .data_in   (data_in),
        .in_ready  (rr_in_ready),
        .out_valid (rr_out_valid),
        .out_data  (rr_out_data),
        .out_port  (rr_out_port),
        .out_ready (out_ready)
    );

    rr_mux_bus #(
        .WIDTH     (W),
        .NUM_PORTS (N),
        .ARB_MODE  (ARB_FIXED)
    ) u_dut_fx (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_lock   (in_lock),
        .data_in   (data_in),
        .in_ready  (fx_in_ready),
        .out_valid (fx_out_valid),
        .out_data  (fx_out_data),
        .out_port  (fx_out_port),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; registered outputs are then settled.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_rr(input string tag, input logic [1:0] port, input logic [7:0] data);
        chk({tag, "_valid"}, 32'(rr_out_valid), 32'd1);
        chk({tag, "_port"}, 32'(rr_out_port), 32'(port));
        chk({tag, "_data"}, 32'(rr_out_data), 32'(data));
    endtask

    initial begin
        data_in   = 32'h89ABCDEF;
        reset     = 1'b1;
        in_valid  = 4'hF;
        in_lock   = 4'h0;
        out_ready = 1'b1;

        // 1: reset held two cycles with all ports requesting
        tick();
        chk("rst_c1_valid", 32'(rr_out_valid), 32'd0);
        chk("rst_c1_data", 32'(rr_out_data), 32'h00);
        chk("rst_c1_ready", 32'(rr_in_ready), 32'h0);
        tick();
        chk("rst_c2_valid", 32'(rr_out_valid), 32'd0);
        chk("rst_c2_ready", 32'(rr_in_ready), 32'h0);
        chk("rst_c2_fx_ready", 32'(fx_in_ready), 32'h0);
        reset = 1'b0;
        #1;
        chk("post_rst_valid", 32'(rr_out_valid), 32'd0);
        chk("post_rst_data", 32'(rr_out_data), 32'h00);
        chk("post_rst_ready", 32'(rr_in_ready), 32'h1);

        // 2: round-robin rotation at full throughput
        tick(); chk_rr("rr0", 2'd0, 8'hEF);
        chk("fx_rr0_port", 32'(fx_out_port), 32'd0);
        tick(); chk_rr("rr1", 2'd1, 8'hCD);
        chk("fx_rr1_port", 32'(fx_out_port), 32'd0);
        tick(); chk_rr("rr2", 2'd2, 8'hAB);
        tick(); chk_rr("rr3", 2'd3, 8'h89);
        tick(); chk_rr("rr4", 2'd0, 8'hEF);

        // 3: backpressure on a single requester (pointer now 1)
        in_valid = 4'b0100;
        #1;
        chk("bp_ready_drain", 32'(rr_in_ready), 32'b0100);
        tick(); chk_rr("bp_w0", 2'd2, 8'hAB);
        out_ready = 1'b0;
        #1;
        chk("bp_ready_full", 32'(rr_in_ready), 32'h0);
        tick(); chk_rr("bp_hold1", 2'd2, 8'hAB);
        chk("bp_hold1_ready", 32'(rr_in_ready), 32'h0);
        tick(); chk_rr("bp_hold2", 2'd2, 8'hAB);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(rr_in_ready), 32'b0100);
        tick(); chk_rr("bp_w1", 2'd2, 8'hAB);
        in_valid = 4'h0;
        tick();
        chk("bp_empty_valid", 32'(rr_out_valid), 32'd0);
        chk("bp_empty_data", 32'(rr_out_data), 32'h00);

        // 4: lock on port 1; first move pointer from 3 to 1 with one port-0 word
        in_valid = 4'b0001;
        tick(); chk_rr("lk_pre", 2'd0, 8'hEF);
        in_valid = 4'hF;
        in_lock  = 4'b0010;
        tick(); chk_rr("lk_w0", 2'd1, 8'hCD);
        tick(); chk_rr("lk_w1", 2'd1, 8'hCD);
        // Owner drops its request while locked: nobody may be granted.
        in_valid = 4'b1101;
        #1;
        chk("lk_bubble_ready", 32'(rr_in_ready), 32'h0);
        in_valid = 4'hF;
        #1;
        chk("lk_owner_ready", 32'(rr_in_ready), 32'b0010);
        tick(); chk_rr("lk_w2", 2'd1, 8'hCD);
        in_lock = 4'h0;
        tick(); chk_rr("lk_w3", 2'd1, 8'hCD);
        tick(); chk_rr("lk_after0", 2'd2, 8'hAB);
        tick(); chk_rr("lk_after1", 2'd3, 8'h89);
        in_valid = 4'h0;
        tick();

        // 5: fixed priority instance from a fresh reset
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fx_all_valid", 32'(fx_out_valid), 32'd1);
            chk("fx_all_port", 32'(fx_out_port), 32'd0);
            chk("fx_all_data", 32'(fx_out_data), 32'hEF);
        end
        in_valid = 4'b1010;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("fx_1010_port", 32'(fx_out_port), 32'd1);
            chk("fx_1010_data", 32'(fx_out_data), 32'hCD);
        end
        in_valid = 4'h0;
        tick();

        // 6: reset while locked to port 3 with a stalled output word
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 4'b1000;
        in_lock  = 4'b1000;
        tick(); chk_rr("mr_w0", 2'd3, 8'h89);
        out_ready = 1'b0;
        in_valid  = 4'hF;
        tick(); chk_rr("mr_stall", 2'd3, 8'h89);
        reset = 1'b1;
        #1;
        chk("mr_rst_ready", 32'(rr_in_ready), 32'h0);
        tick();
        chk("mr_rst_valid", 32'(rr_out_valid), 32'd0);
        chk("mr_rst_data", 32'(rr_out_data), 32'h00);
        reset     = 1'b0;
        in_lock   = 4'h0;
        out_ready = 1'b1;
        #1;
        chk("mr_first_ready", 32'(rr_in_ready), 32'b0001);
        tick(); chk_rr("mr_first", 2'd0, 8'hEF);
        tick(); chk_rr("mr_second", 2'd1, 8'hCD);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
